// File: rtl/btn_event_sched_pkg.sv
// Shared definitions for the button event scheduler: event codes, per-button
// FSM state encoding and the ceil(log2) helper used to size ports and counters.
package btn_event_sched_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RPT     = 2'd2,
        ST_LOCKOUT = 2'd3
    } btn_state_e;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clogb2(input int value);
        int v;
        int w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// One button's event generator: press/hold/repeat FSM with its hold counter,
// previous-level register and a single-entry pending-event slot.
module btn_event_fsm
    import btn_event_sched_pkg::*;
#(
    parameter int LONG_CLKS   = 100_000_000,
    parameter int REPEAT_CLKS = 20_000_000,
    parameter int CNT_W       = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    input  logic       grant_i,
    output logic       slot_vld_o,
    output logic [1:0] slot_type_o,
    output logic       ovf_set_o
);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             slot_vld_q, slot_vld_d;
    logic [1:0]       slot_type_q, slot_type_d;
    logic             post_vld;
    logic [1:0]       post_type;
    logic             occupied;

    // State register; a button already held at reset is locked out until released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= btn_i ? ST_LOCKOUT : ST_IDLE;
            slot_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_vld_q <= slot_vld_d;
        end
        prev_q      <= btn_i;
        cnt_q       <= cnt_d;
        slot_type_q <= slot_type_d;
    end

    // Next-state: release always wins over counter expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (btn_i && !prev_q) state_d = ST_HOLD;
            ST_HOLD:    if (!btn_i) state_d = ST_IDLE;
                        else if (cnt_q == '0) state_d = ST_RPT;
            ST_RPT:     if (!btn_i) state_d = ST_IDLE;
            ST_LOCKOUT: if (!btn_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: event to post and hold-counter update.
    always_comb begin
        post_vld  = 1'b0;
        post_type = EVT_PRESS;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_i && !prev_q) begin
                    post_vld  = 1'b1;
                    post_type = EVT_PRESS;
                    cnt_d     = CNT_W'(LONG_CLKS - 1);
                end
            end
            ST_HOLD, ST_RPT: begin
                if (!btn_i) begin
                    post_vld  = 1'b1;
                    post_type = EVT_RELEASE;
                end else if (cnt_q == '0) begin
                    post_vld  = 1'b1;
                    post_type = (state_q == ST_HOLD) ? EVT_LONG : EVT_REPEAT;
                    cnt_d     = CNT_W'(REPEAT_CLKS - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Pending slot: a grant frees it first, so a same-cycle post never overflows;
    // repeats are droppable, other events overwrite and flag the loss.
    always_comb begin
        occupied    = slot_vld_q && !grant_i;
        slot_vld_d  = occupied;
        slot_type_d = slot_type_q;
        ovf_set_o   = 1'b0;
        if (post_vld) begin
            if (!occupied) begin
                slot_vld_d  = 1'b1;
                slot_type_d = post_type;
            end else if (post_type != EVT_REPEAT) begin
                slot_type_d = post_type;
                ovf_set_o   = 1'b1;
            end
        end
    end

    assign slot_vld_o  = slot_vld_q;
    assign slot_type_o = slot_type_q;

endmodule

// File: rtl/btn_event_sched.sv
// Button event scheduler: per-button event FSMs feeding a round-robin arbiter
// that serialises events onto one valid/ready stream, plus sticky overflow flags.
module btn_event_sched
    import btn_event_sched_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int LONG_CLKS   = 100_000_000,
    parameter int REPEAT_CLKS = 20_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         btn_db,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [clogb2(NUM_BTN)-1:0] evt_btn,
    output logic [1:0]                 evt_type,
    output logic [NUM_BTN-1:0]         ovf,
    input  logic                       ovf_clr
);

    localparam int BTN_W = clogb2(NUM_BTN);
    localparam int CNT_W = clogb2((LONG_CLKS > REPEAT_CLKS) ? LONG_CLKS : REPEAT_CLKS);

    logic [NUM_BTN-1:0]       slot_vld;
    logic [NUM_BTN-1:0][1:0]  slot_type;
    logic [NUM_BTN-1:0]       ovf_set;
    logic [NUM_BTN-1:0]       gnt_vec;
    logic                     load_en;
    logic                     found;
    logic [BTN_W-1:0]         gnt_idx;
    logic [BTN_W-1:0]         ptr_q;
    logic                     evt_valid_q;
    logic [BTN_W-1:0]         evt_btn_q;
    logic [1:0]               evt_type_q;
    logic [NUM_BTN-1:0]       ovf_q, ovf_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_event_fsm #(
            .LONG_CLKS   (LONG_CLKS),
            .REPEAT_CLKS (REPEAT_CLKS),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk         (clk),
            .rst         (rst),
            .btn_i       (btn_db[i]),
            .grant_i     (gnt_vec[i]),
            .slot_vld_o  (slot_vld[i]),
            .slot_type_o (slot_type[i]),
            .ovf_set_o   (ovf_set[i])
        );
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        int idx;
        idx     = 0;
        load_en = !evt_valid_q || evt_ready;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_BTN; k++) begin
            idx = (int'(ptr_q) + k) % NUM_BTN;
            if (!found && slot_vld[idx]) begin
                found   = 1'b1;
                gnt_idx = idx[BTN_W-1:0];
            end
        end
        gnt_vec = '0;
        if (load_en && found) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    // Output register: reloads when empty or accepted, holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_btn_q   <= '0;
            evt_type_q  <= EVT_PRESS;
            ptr_q       <= '0;
        end else if (load_en) begin
            evt_valid_q <= found;
            if (found) begin
                evt_btn_q  <= gnt_idx;
                evt_type_q <= slot_type[gnt_idx];
                ptr_q      <= gnt_idx;
            end
        end
    end

    // Sticky overflow: a set in the same cycle as a clear wins.
    always_comb begin
        ovf_d = (ovf_q & ~{NUM_BTN{ovf_clr}}) | ovf_set;
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_btn   = evt_btn_q;
    assign evt_type  = evt_type_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_sched.sv
// Scoreboard bench for btn_event_sched: a behavioural model tracks how long each
// button has been held and queues the events the arbiter should emit; a monitor
// pops and compares every accepted event.
module tb_btn_event_sched;

    localparam int NB = 4;
    localparam int LC = 10;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_db;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_btn;
    logic [1:0]    evt_type;
    logic [NB-1:0] ovf;
    logic          ovf_clr;

    always #5 clk = ~clk;

    btn_event_sched #(
        .NUM_BTN     (NB),
        .LONG_CLKS   (LC),
        .REPEAT_CLKS (RC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_db    (btn_db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_type  (evt_type),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    typedef struct packed {
        logic [1:0] b;
        logic [1:0] t;
    } ev_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];
    ev_t mon_e;

    // Reference model state: hold age per button (-1 = not held), lockout,
    // pending event per button, output-occupied flag, last grant, overflow.
    int            held[NB];
    bit            lock[NB];
    bit            pv[NB];
    logic [1:0]    pt[NB];
    bit            m_out_v;
    int            m_ptr;
    logic [NB-1:0] m_ovf;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    function automatic void model_step(input logic [NB-1:0] b, input logic r,
                                       input logic c, input logic rs);
        logic [NB-1:0] set;
        int ev;
        ev_t e;
        if (rs) begin
            for (int i = 0; i < NB; i++) begin
                held[i] = -1;
                lock[i] = b[i];
                pv[i]   = 1'b0;
            end
            m_out_v = 1'b0;
            m_ptr   = 0;
            m_ovf   = '0;
            exp_q.delete();
            return;
        end
        if (!m_out_v || r) begin
            m_out_v = 1'b0;
            for (int k = 1; k <= NB; k++) begin
                int j;
                j = (m_ptr + k) % NB;
                if (pv[j]) begin
                    e.b = j[1:0];
                    e.t = pt[j];
                    exp_q.push_back(e);
                    pv[j]   = 1'b0;
                    m_ptr   = j;
                    m_out_v = 1'b1;
                    break;
                end
            end
        end
        set = '0;
        for (int i = 0; i < NB; i++) begin
            ev = -1;
            if (lock[i]) begin
                if (!b[i]) lock[i] = 1'b0;
            end else if (held[i] < 0) begin
                if (b[i]) begin
                    ev = 0;
                    held[i] = 0;
                end
            end else if (!b[i]) begin
                ev = 1;
                held[i] = -1;
            end else begin
                held[i]++;
                if (held[i] == LC) ev = 2;
                else if (held[i] > LC && (held[i] - LC) % RC == 0) ev = 3;
            end
            if (ev >= 0) begin
                if (pv[i]) begin
                    if (ev != 3) begin
                        pt[i]  = ev[1:0];
                        set[i] = 1'b1;
                    end
                end else begin
                    pv[i] = 1'b1;
                    pt[i] = ev[1:0];
                end
            end
        end
        m_ovf = (c ? '0 : m_ovf) | set;
    endfunction

    // One clock: drive inputs, advance the model, check valid and ovf after the edge.
    task automatic cyc(input logic [NB-1:0] b, input logic r, input logic c, input logic rs);
        btn_db    = b;
        evt_ready = r;
        ovf_clr   = c;
        rst       = rs;
        model_step(b, r, c, rs);
        @(posedge clk);
        #1;
        cmp("evt_valid", 32'(evt_valid), 32'(m_out_v));
        cmp("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic run(input logic [NB-1:0] b, input int n);
        for (int i = 0; i < n; i++) cyc(b, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_evt: got btn %0d type %0d, expected no event (t=%0t)",
                         evt_btn, evt_type, $time);
            end else begin
                mon_e = exp_q.pop_front();
                cmp("evt_btn", 32'(evt_btn), 32'(mon_e.b));
                cmp("evt_type", 32'(evt_type), 32'(mon_e.t));
            end
        end
    end

    initial begin
        logic [NB-1:0] rb;
        // reset state
        cyc('0, 1'b1, 1'b0, 1'b1);
        cyc('0, 1'b1, 1'b0, 1'b1);
        cmp("rst_evt_btn", 32'(evt_btn), 32'd0);
        cmp("rst_evt_type", 32'(evt_type), 32'd0);
        cmp("rst_ovf", 32'(ovf), 32'd0);

        // long hold with repeats, then release
        run(4'b0010, 25);
        run(4'b0000, 6);
        // short press
        run(4'b0100, 5);
        run(4'b0000, 5);
        // simultaneous bursts from a fresh pointer
        cyc('0, 1'b1, 1'b0, 1'b1);
        run(4'b1111, 6);
        run(4'b0000, 8);

        // stalled output with slot overwrite, then clear
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        cmp("stall_ovf", 32'(ovf), 32'h1);
        cmp("stall_btn", 32'(evt_btn), 32'd0);
        cmp("stall_type", 32'(evt_type), 32'd0);
        cyc(4'b0001, 1'b0, 1'b1, 1'b0);
        cmp("ovf_cleared", 32'(ovf), 32'h0);
        run(4'b0001, 3);
        run(4'b0000, 6);

        // button held through reset is locked out
        cyc(4'b1000, 1'b1, 1'b0, 1'b1);
        cyc(4'b1000, 1'b1, 1'b0, 1'b1);
        run(4'b1000, 5);
        run(4'b0000, 3);
        run(4'b1000, 3);
        run(4'b0000, 5);

        // reset with events in flight
        cyc(4'b0111, 1'b0, 1'b0, 1'b0);
        cyc(4'b0111, 1'b0, 1'b0, 1'b0);
        cyc(4'b0111, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1);
        run(4'b0000, 6);

        // randomized traffic
        rb = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 15) == 0) rb[i] = ~rb[i];
            end
            cyc(rb, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                $urandom_range(0, 999) == 0);
        end

        // drain
        run(4'b0000, 40);
        cmp("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
